cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle CPU control sequencer (fetch/decode/exec/mem/wb)
// Controls are registered Moore outputs; only the FETCH ir_en/pc_en strobes follow mem_ack directly.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic [3:0]  i_op,
  input  logic [3:0]  i_flags,
  input  logic        i_mem_ack,
  output logic        o_ir_en,
  output logic        o_pc_en,
  output logic        o_pc_sel,
  output logic        o_mem_req,
  output logic        o_mem_rw,
  output logic        o_mem_sel,
  output logic        o_w_en,
  output logic        o_flag_en,
  output logic [2:0]  o_state,
  output logic        o_halted,
  output logic        o_error,
  output logic [15:0] o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;
  localparam logic [3:0] OP_BZ    = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd15;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [3:0]  r_op;
  logic [7:0]  r_wait;
  logic [15:0] r_instr_count;
  logic        r_pc_en;
  logic        r_pc_sel;
  logic        r_mem_req;
  logic        r_mem_rw;
  logic        r_mem_sel;
  logic        r_w_en;
  logic        r_flag_en;
  logic        r_halted;
  logic        r_error;

  state_t      w_next_fetch;
  logic        w_fetch_ack;
  logic        w_timeout;
  logic        w_unused_flags;

  assign w_fetch_ack    = (r_state == S_FETCH) && i_mem_ack;
  assign w_next_fetch   = i_run ? S_FETCH : S_IDLE;
  assign w_timeout      = (r_wait == WAIT_LAST);
  assign w_unused_flags = ^i_flags[3:1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_op          <= 4'd0;
      r_wait        <= 8'd0;
      r_instr_count <= 16'd0;
      r_pc_en       <= 1'b0;
      r_pc_sel      <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_sel     <= 1'b0;
      r_w_en        <= 1'b0;
      r_flag_en     <= 1'b0;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_pc_en   <= 1'b0;
      r_pc_sel  <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_rw  <= 1'b0;
      r_mem_sel <= 1'b0;
      r_w_en    <= 1'b0;
      r_flag_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
            r_wait    <= 8'd0;
          end
        end
        S_FETCH: begin
          if (i_mem_ack) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
          end else begin
            r_wait    <= r_wait + 8'd1;
            r_mem_req <= 1'b1;
          end
        end
        // EXEC controls are registered here, from the opcode being latched.
        S_DECODE: begin
          r_op    <= i_op;
          r_state <= S_EXEC;
          if (!i_op[3]) begin
            r_flag_en <= 1'b1;
          end else if (i_op == OP_JMP) begin
            r_pc_en  <= 1'b1;
            r_pc_sel <= 1'b1;
          end else if (i_op == OP_BZ) begin
            r_pc_en  <= i_flags[0];
            r_pc_sel <= i_flags[0];
          end
        end
        S_EXEC: begin
          if (!r_op[3]) begin
            r_state <= S_WB;
            r_w_en  <= 1'b1;
          end else if (r_op == OP_LOAD || r_op == OP_STORE) begin
            r_state   <= S_MEM;
            r_mem_req <= 1'b1;
            r_mem_rw  <= (r_op == OP_STORE);
            r_wait    <= 8'd0;
          end else if (r_op == OP_HALT) begin
            r_state       <= S_HALT;
            r_halted      <= 1'b1;
            r_instr_count <= r_instr_count + 16'd1;
          end else begin
            r_state       <= w_next_fetch;
            r_mem_req     <= i_run;
            r_wait        <= 8'd0;
            r_instr_count <= r_instr_count + 16'd1;
          end
        end
        S_MEM: begin
          if (i_mem_ack) begin
            if (r_op == OP_STORE) begin
              r_state       <= w_next_fetch;
              r_mem_req     <= i_run;
              r_wait        <= 8'd0;
              r_instr_count <= r_instr_count + 16'd1;
            end else begin
              r_state   <= S_WB;
              r_w_en    <= 1'b1;
              r_mem_sel <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
          end else begin
            r_wait    <= r_wait + 8'd1;
            r_mem_req <= 1'b1;
            r_mem_rw  <= r_mem_rw;
          end
        end
        S_WB: begin
          r_state       <= w_next_fetch;
          r_mem_req     <= i_run;
          r_wait        <= 8'd0;
          r_instr_count <= r_instr_count + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ir_en       = w_fetch_ack;
  assign o_pc_en       = r_pc_en | w_fetch_ack;
  assign o_pc_sel      = r_pc_sel;
  assign o_mem_req     = r_mem_req;
  assign o_mem_rw      = r_mem_rw;
  assign o_mem_sel     = r_mem_sel;
  assign o_w_en        = r_w_en;
  assign o_flag_en     = r_flag_en;
  assign o_state       = r_state;
  assign o_halted      = r_halted;
  assign o_error       = r_error;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
// Each record holds one cycle's stimulus and the state/controls/count/status expected in that cycle.
module tb_cpu_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_ERR = 3'd7;
  // control order: {ir_en, pc_en, pc_sel, mem_req, mem_rw, mem_sel, w_en, flag_en}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_FREQ = 8'b0001_0000;
  localparam logic [7:0] C_FACK = 8'b1101_0000;
  localparam logic [7:0] C_ALU  = 8'b0000_0001;
  localparam logic [7:0] C_WBA  = 8'b0000_0010;
  localparam logic [7:0] C_WBL  = 8'b0000_0110;
  localparam logic [7:0] C_MRD  = 8'b0001_0000;
  localparam logic [7:0] C_MWR  = 8'b0001_1000;
  localparam logic [7:0] C_BR   = 8'b0110_0000;

  typedef struct {
    logic        run;
    logic        ack;
    logic [3:0]  op;
    logic [3:0]  flags;
    logic [2:0]  st;
    logic [7:0]  ctl;
    logic [15:0] cnt;
    logic [1:0]  he;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, run, ack;
  logic [3:0]  op, flags;
  logic        o_ir_en, o_pc_en, o_pc_sel, o_mem_req, o_mem_rw, o_mem_sel, o_w_en, o_flag_en;
  logic [2:0]  o_state;
  logic        o_halted, o_error;
  logic [15:0] o_instr_count;
  logic [7:0]  w_ctl;

  rec_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_cnt;
  logic [1:0]  m_he;

  cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_op(op), .i_flags(flags), .i_mem_ack(ack),
    .o_ir_en(o_ir_en), .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel), .o_mem_req(o_mem_req),
    .o_mem_rw(o_mem_rw), .o_mem_sel(o_mem_sel), .o_w_en(o_w_en), .o_flag_en(o_flag_en),
    .o_state(o_state), .o_halted(o_halted), .o_error(o_error), .o_instr_count(o_instr_count)
  );

  assign w_ctl = {o_ir_en, o_pc_en, o_pc_sel, o_mem_req, o_mem_rw, o_mem_sel, o_w_en, o_flag_en};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input logic a_run, input logic a_ack, input logic [3:0] a_op,
                      input logic [3:0] a_flags, input logic [2:0] a_st, input logic [7:0] a_ctl);
    sb.push_back('{a_run, a_ack, a_op, a_flags, a_st, a_ctl, m_cnt, m_he});
  endtask

  // Called at a falling edge: drives one record, samples mid-cycle, advances one cycle.
  task automatic apply(output rec_t e, output logic [28:0] obs);
    e = sb.pop_front();
    run = e.run; ack = e.ack; op = e.op; flags = e.flags;
    #1;
    obs = {o_state, w_ctl, o_instr_count, o_halted, o_error};
    @(negedge clk);
  endtask

  task automatic test_reset;
    rec_t e; logic [28:0] obs;
    run = 1'b0; ack = 1'b1; op = 4'd0; flags = 4'd0; rst = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({o_state, w_ctl, o_instr_count, o_halted, o_error} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_state got st=%0d ctl=%b cnt=%h h=%b e=%b want all zero",
               o_state, w_ctl, o_instr_count, o_halted, o_error);
    end
    @(negedge clk);
    rst = 1'b0; m_cnt = 16'd0; m_he = 2'b00;
    repeat (3) push(1'b0, 1'b1, 4'd0, 4'd0, ST_IDLE, C_NONE);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL reset_idle got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
  endtask

  task automatic test_alu;
    rec_t e; logic [28:0] obs;
    push(1, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    push(1, 1, 4'd0, 4'd0, ST_FETCH, C_FACK);
    push(1, 1, 4'd3, 4'd0, ST_DEC, C_NONE);
    push(1, 1, 4'd9, 4'd0, ST_EXEC, C_ALU);
    push(1, 0, 4'd9, 4'd0, ST_WB, C_WBA); m_cnt++;
    push(1, 1, 4'd0, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd7, 4'd0, ST_DEC, C_NONE);
    push(0, 0, 4'd8, 4'd0, ST_EXEC, C_ALU);
    push(0, 0, 4'd8, 4'd0, ST_WB, C_WBA); m_cnt++;
    push(0, 1, 4'd0, 4'd0, ST_IDLE, C_NONE);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL alu got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
  endtask

  task automatic test_load_store;
    rec_t e; logic [28:0] obs;
    push(1, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    push(1, 1, 4'd8, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd8, 4'd0, ST_DEC, C_NONE);
    push(1, 0, 4'd3, 4'd0, ST_EXEC, C_NONE);
    repeat (3) push(1, 0, 4'd3, 4'd0, ST_MEM, C_MRD);
    push(1, 1, 4'd3, 4'd0, ST_MEM, C_MRD);
    push(1, 0, 4'd0, 4'd0, ST_WB, C_WBL); m_cnt++;
    push(1, 1, 4'd9, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd9, 4'd0, ST_DEC, C_NONE);
    push(1, 0, 4'd9, 4'd0, ST_EXEC, C_NONE);
    push(1, 0, 4'd9, 4'd0, ST_MEM, C_MWR);
    push(0, 1, 4'd9, 4'd0, ST_MEM, C_MWR); m_cnt++;
    push(0, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL load_store got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
  endtask

  task automatic test_branch;
    rec_t e; logic [28:0] obs;
    push(1, 0, 4'd0,  4'd0, ST_IDLE, C_NONE);
    push(1, 1, 4'd0,  4'd1, ST_FETCH, C_FACK);
    push(1, 0, 4'd11, 4'd1, ST_DEC, C_NONE);
    push(1, 0, 4'd11, 4'd1, ST_EXEC, C_BR); m_cnt++;
    push(1, 1, 4'd0,  4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd11, 4'd0, ST_DEC, C_NONE);
    push(1, 0, 4'd11, 4'd0, ST_EXEC, C_NONE); m_cnt++;
    push(1, 1, 4'd0,  4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd10, 4'd0, ST_DEC, C_NONE);
    push(1, 0, 4'd10, 4'd0, ST_EXEC, C_BR); m_cnt++;
    push(1, 1, 4'd0,  4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd13, 4'd0, ST_DEC, C_NONE);
    push(0, 0, 4'd13, 4'd0, ST_EXEC, C_NONE); m_cnt++;
    push(0, 0, 4'd0,  4'd0, ST_IDLE, C_NONE);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL branch got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
  endtask

  task automatic test_timeout;
    rec_t e; logic [28:0] obs;
    push(1, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    repeat (14) push(1, 0, 4'd0, 4'd0, ST_FETCH, C_FREQ);
    push(1, 1, 4'd0, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd12, 4'd0, ST_DEC, C_NONE);
    push(0, 0, 4'd12, 4'd0, ST_EXEC, C_NONE); m_cnt++;
    push(1, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    repeat (15) push(1, 0, 4'd0, 4'd0, ST_FETCH, C_FREQ);
    m_he = 2'b01;
    push(1, 1, 4'd0, 4'd0, ST_ERR, C_NONE);
    push(0, 1, 4'd3, 4'd0, ST_ERR, C_NONE);
    push(1, 0, 4'd8, 4'd0, ST_ERR, C_NONE);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL timeout got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
    rst = 1'b1; #1;
    vectors++;
    if ({o_state, w_ctl, o_instr_count, o_halted, o_error} !== 29'd0) begin
      miscompares++;
      $display("FAIL error_reset got st=%0d ctl=%b cnt=%h h=%b e=%b want all zero",
               o_state, w_ctl, o_instr_count, o_halted, o_error);
    end
    @(negedge clk);
    rst = 1'b0; m_cnt = 16'd0; m_he = 2'b00;
  endtask

  task automatic test_halt_reset;
    rec_t e; logic [28:0] obs;
    push(1, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    push(1, 1, 4'd0, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd15, 4'd0, ST_DEC, C_NONE);
    push(0, 0, 4'd3, 4'd0, ST_EXEC, C_NONE); m_cnt++; m_he = 2'b10;
    push(1, 1, 4'd8, 4'd1, ST_HALT, C_NONE);
    push(0, 0, 4'd10, 4'd0, ST_HALT, C_NONE);
    push(1, 1, 4'd3, 4'd0, ST_HALT, C_NONE);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL halt got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
    rst = 1'b1; #1;
    vectors++;
    if ({o_state, w_ctl, o_instr_count, o_halted, o_error} !== 29'd0) begin
      miscompares++;
      $display("FAIL halt_reset got st=%0d ctl=%b cnt=%h h=%b e=%b want all zero",
               o_state, w_ctl, o_instr_count, o_halted, o_error);
    end
    @(negedge clk);
    rst = 1'b0; m_cnt = 16'd0; m_he = 2'b00;
    push(1, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    push(1, 1, 4'd0, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd10, 4'd0, ST_DEC, C_NONE);
    push(1, 0, 4'd10, 4'd0, ST_EXEC, C_BR); m_cnt++;
    push(1, 1, 4'd0, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd8, 4'd0, ST_DEC, C_NONE);
    push(1, 0, 4'd8, 4'd0, ST_EXEC, C_NONE);
    push(1, 0, 4'd8, 4'd0, ST_MEM, C_MRD);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL pre_mem_reset got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
    // Still waiting in MEM: reset lands mid-cycle, away from any clock edge.
    ack = 1'b0; run = 1'b1; #2;
    vectors++;
    if ({o_state, o_mem_req, o_instr_count} !== {ST_MEM, 1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL mem_wait got st=%0d req=%b cnt=%h want st=4 req=1 cnt=0001",
               o_state, o_mem_req, o_instr_count);
    end
    rst = 1'b1; #1;
    vectors++;
    if ({o_state, w_ctl, o_instr_count, o_halted, o_error} !== 29'd0) begin
      miscompares++;
      $display("FAIL mem_async_reset got st=%0d ctl=%b cnt=%h h=%b e=%b want all zero",
               o_state, w_ctl, o_instr_count, o_halted, o_error);
    end
    ack = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({o_state, w_ctl, o_instr_count, o_halted, o_error} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_hold got st=%0d ctl=%b cnt=%h h=%b e=%b want all zero",
               o_state, w_ctl, o_instr_count, o_halted, o_error);
    end
    @(negedge clk);
    rst = 1'b0; m_cnt = 16'd0; m_he = 2'b00;
  endtask

  task automatic test_run_drop_wrap;
    rec_t e; logic [28:0] obs;
    force dut.r_instr_count = 16'hFFFF;
    #1;
    release dut.r_instr_count;
    m_cnt = 16'hFFFF;
    push(1, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    push(1, 1, 4'd0, 4'd0, ST_FETCH, C_FACK);
    push(1, 0, 4'd5, 4'd0, ST_DEC, C_NONE);
    push(0, 0, 4'd5, 4'd0, ST_EXEC, C_ALU);
    push(0, 0, 4'd5, 4'd0, ST_WB, C_WBA); m_cnt++;
    push(0, 1, 4'd0, 4'd0, ST_IDLE, C_NONE);
    push(0, 0, 4'd0, 4'd0, ST_IDLE, C_NONE);
    while (sb.size() > 0) begin
      apply(e, obs); vectors++;
      if (obs !== {e.st, e.ctl, e.cnt, e.he}) begin
        miscompares++;
        $display("FAIL run_drop_wrap got st=%0d ctl=%b cnt=%h he=%b want st=%0d ctl=%b cnt=%h he=%b",
                 obs[28:26], obs[25:18], obs[17:2], obs[1:0], e.st, e.ctl, e.cnt, e.he);
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; ack = 1'b0; op = 4'd0; flags = 4'd0;
    m_cnt = 16'd0; m_he = 2'b00;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_timeout();
    test_halt_reset();
    test_run_drop_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
